cdb_slot_scheduler: RTL and testbench

- Parametrised issue-grant and common-data-bus (CDB) slot scheduler for NUM_FU functional units.
- Each FU has a fixed result latency. The block books future CDB cycles in a reservation shift register and issues only when the target slot is free.
- Round-robin priority resolves same-slot contention. Non-pipelined units are held busy until their result broadcasts.
- Sits between the reservation-station ready logic and the FU group, and drives the one-hot CDB result mux plus the CDB output.

---
 rtl/cdb_slot_scheduler.sv | 154 +++++++++++++++
 tb/tb_cdb_slot_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_slot_scheduler.sv
// Issue-grant and CDB slot scheduler: books future CDB cycles per FU latency,
// arbitrates same-slot contention round-robin and drives the CDB result mux.
module cdb_slot_scheduler #(
    parameter int                    NUM_FU       = 4,
    parameter int                    MAX_LAT      = 8,
    parameter logic [NUM_FU*4-1:0]   FU_LAT       = {4'd1, 4'd3, 4'd6, 4'd0},
    parameter logic [NUM_FU-1:0]     NONPIPE_MASK = 4'b0010,
    parameter int                    RES_W        = 38,
    parameter int                    IDX_W        = $clog2(NUM_FU)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic [NUM_FU-1:0]       i_ready,
    input  logic [NUM_FU*RES_W-1:0] i_fu_result,
    output logic [NUM_FU-1:0]       o_issue,
    output logic [NUM_FU-1:0]       o_fu_busy,
    output logic                    o_cdb_valid,
    output logic [IDX_W-1:0]        o_cdb_src,
    output logic [RES_W-1:0]        o_cdb_data
);

    localparam int SLOT_W = $clog2(MAX_LAT);

    // Handshake: o_issue[i] is a single-cycle grant; the RS must treat an
    // unanswered i_ready as dropped and re-request in a later cycle.
    logic [MAX_LAT-1:0] resv_vld;
    logic [IDX_W-1:0]   resv_own [MAX_LAT];
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_FU-1:0]  busy;

    logic [MAX_LAT-1:0] vld_nxt;
    logic [IDX_W-1:0]   own_nxt [MAX_LAT];
    logic [IDX_W-1:0]   rr_nxt;
    logic [NUM_FU-1:0]  busy_nxt;

    logic [3:0]         fu_lat [NUM_FU];
    logic [NUM_FU-1:0]  grant;
    logic [MAX_LAT-1:0] slot_taken;
    logic               found;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W:0]     scan_sum;
    logic [IDX_W-1:0]   scan_idx;
    logic [SLOT_W-1:0]  scan_lat;
    logic [SLOT_W-1:0]  book_slot;
    logic               cdb_has;
    logic [IDX_W-1:0]   cdb_own;
    logic               cdb_fire;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_lat
        assign fu_lat[g] = FU_LAT[g*4 +: 4];
    end

    // Scan from rr_ptr; a slot claimed earlier in the scan blocks later FUs.
    always_comb begin
        grant      = '0;
        slot_taken = '0;
        found      = 1'b0;
        first_idx  = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        scan_lat   = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(j);
            if (scan_sum >= (IDX_W+1)'(NUM_FU))
                scan_sum = scan_sum - (IDX_W+1)'(NUM_FU);
            scan_idx = scan_sum[IDX_W-1:0];
            scan_lat = SLOT_W'(fu_lat[scan_idx]);
            if (i_ready[scan_idx] && !busy[scan_idx] && !i_flush &&
                !resv_vld[scan_lat] && !slot_taken[scan_lat]) begin
                grant[scan_idx]      = 1'b1;
                slot_taken[scan_lat] = 1'b1;
                if (!found) begin
                    found     = 1'b1;
                    first_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        cdb_has = resv_vld[0];
        cdb_own = resv_own[0];
        if (!resv_vld[0]) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant[i] && fu_lat[i] == 4'd0) begin
                    cdb_has = 1'b1;
                    cdb_own = IDX_W'(i);
                end
            end
        end
    end

    assign cdb_fire    = cdb_has && !i_flush && !i_rst;
    assign o_issue     = i_rst ? '0 : grant;
    assign o_fu_busy   = i_rst ? '0 : busy;
    assign o_cdb_valid = cdb_fire;
    assign o_cdb_src   = cdb_fire ? cdb_own : '0;

    always_comb begin
        o_cdb_data = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (cdb_fire && cdb_own == IDX_W'(i))
                o_cdb_data = i_fu_result[i*RES_W +: RES_W];
        end
    end

    // Shift the booking window, then record this cycle's L>=1 grants.
    always_comb begin
        vld_nxt   = {1'b0, resv_vld[MAX_LAT-1:1]};
        book_slot = '0;
        for (int k = 0; k < MAX_LAT-1; k++)
            own_nxt[k] = resv_own[k+1];
        own_nxt[MAX_LAT-1] = '0;
        busy_nxt = busy;
        if (cdb_has)
            busy_nxt[cdb_own] = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i] && fu_lat[i] != 4'd0) begin
                book_slot          = SLOT_W'(fu_lat[i] - 4'd1);
                vld_nxt[book_slot] = 1'b1;
                own_nxt[book_slot] = IDX_W'(i);
                if (NONPIPE_MASK[i])
                    busy_nxt[i] = 1'b1;
            end
        end
        if (!found)
            rr_nxt = rr_ptr;
        else if (first_idx == IDX_W'(NUM_FU-1))
            rr_nxt = '0;
        else
            rr_nxt = first_idx + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            resv_vld <= '0;
            for (int k = 0; k < MAX_LAT; k++)
                resv_own[k] <= '0;
            busy   <= '0;
            rr_ptr <= '0;
        end else if (i_flush) begin
            resv_vld <= '0;
            busy     <= '0;
        end else begin
            resv_vld <= vld_nxt;
            for (int k = 0; k < MAX_LAT; k++)
                resv_own[k] <= own_nxt[k];
            busy   <= busy_nxt;
            rr_ptr <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench: dut_a uses default latencies, dut_b has every FU at latency 2.
// Expected broadcasts are queued by the driver and popped by per-DUT monitors.
module tb_cdb_slot_scheduler;
    localparam int NUM_FU = 4;
    localparam int RES_W  = 38;
    localparam int IDX_W  = 2;
    localparam int W      = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_FU-1:0]       ready_a, ready_b;
    logic                    flush_a, flush_b;
    logic [NUM_FU*RES_W-1:0] fu_result;
    logic [NUM_FU-1:0]       issue_a, issue_b, busy_a, busy_b;
    logic                    cdb_valid_a, cdb_valid_b;
    logic [IDX_W-1:0]        src_a, src_b;
    logic [RES_W-1:0]        data_a, data_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    cdb_slot_scheduler dut_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush_a), .i_ready(ready_a),
        .i_fu_result(fu_result), .o_issue(issue_a), .o_fu_busy(busy_a),
        .o_cdb_valid(cdb_valid_a), .o_cdb_src(src_a), .o_cdb_data(data_a)
    );

    cdb_slot_scheduler #(.FU_LAT(16'h2222)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush_b), .i_ready(ready_b),
        .i_fu_result(fu_result), .o_issue(issue_b), .o_fu_busy(busy_b),
        .o_cdb_valid(cdb_valid_b), .o_cdb_src(src_b), .o_cdb_data(data_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RES_W-1:0] res_word(input int i);
        return {6'h15, 32'hC0DE_0000 + 32'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next(input logic [3:0] ra, input logic fa, input logic [3:0] rb);
        @(posedge clk);
        #1;
        ready_a = ra;
        flush_a = fa;
        ready_b = rb;
        flush_b = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) next(4'h0, 1'b0, 4'h0);
    endtask

    task automatic push_a(input int c, input int src);
        exp_a.push_back({32'(c), 8'(src)});
    endtask

    task automatic push_b(input int c, input int src);
        exp_b.push_back({32'(c), 8'(src)});
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            while (exp_a.size() > 0 && int'(exp_a[0][39:8]) < cyc) begin
                e = exp_a.pop_front();
                check("cdb_a_missing", 64'(e[7:0]), 64'hFF);
            end
            if (cdb_valid_a) begin
                if (exp_a.size() == 0) begin
                    check("cdb_a_unexpected_valid", 64'(src_a), 64'hFF);
                end else begin
                    e = exp_a.pop_front();
                    check("cdb_a_cycle", 64'(cyc), 64'(e[39:8]));
                    check("cdb_a_src", 64'(src_a), 64'(e[7:0]));
                    check("cdb_a_data", 64'(data_a), 64'(res_word(int'(e[7:0]))));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            while (exp_b.size() > 0 && int'(exp_b[0][39:8]) < cyc) begin
                e = exp_b.pop_front();
                check("cdb_b_missing", 64'(e[7:0]), 64'hFF);
            end
            if (cdb_valid_b) begin
                if (exp_b.size() == 0) begin
                    check("cdb_b_unexpected_valid", 64'(src_b), 64'hFF);
                end else begin
                    e = exp_b.pop_front();
                    check("cdb_b_cycle", 64'(cyc), 64'(e[39:8]));
                    check("cdb_b_src", 64'(src_b), 64'(e[7:0]));
                    check("cdb_b_data", 64'(data_b), 64'(res_word(int'(e[7:0]))));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] t4_issue [5];
        int         t4_src   [5];
        int         t0;
        t4_issue = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t4_src   = '{0, 1, 2, 3, 0};
        ready_a = '0; ready_b = '0; flush_a = 1'b0; flush_b = 1'b0;
        for (int i = 0; i < NUM_FU; i++) fu_result[i*RES_W +: RES_W] = res_word(i);

        // Reset: outputs held low even with requests present.
        @(posedge clk); #1;
        ready_a = 4'hF; ready_b = 4'hF; #1;
        check("rst_issue_a", 64'(issue_a), 64'h0);
        check("rst_busy_a", 64'(busy_a), 64'h0);
        check("rst_valid_a", 64'(cdb_valid_a), 64'h0);
        check("rst_data_a", 64'(data_a), 64'h0);
        check("rst_issue_b", 64'(issue_b), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; ready_a = '0; ready_b = '0;

        // Test 1: all FUs at once, distinct latencies.
        next(4'hF, 1'b0, 4'h0);
        t0 = cyc;
        check("t1_issue", 64'(issue_a), 64'hF);
        check("t1_busy_t0", 64'(busy_a), 64'h0);
        push_a(t0, 0); push_a(t0 + 1, 3); push_a(t0 + 3, 2); push_a(t0 + 6, 1);
        for (int k = 1; k <= 7; k++) begin
            next(4'h0, 1'b0, 4'h0);
            check("t1_busy_fu1", 64'(busy_a[1]), (k <= 6) ? 64'h1 : 64'h0);
        end
        idle(2);

        // Test 2: mem request collides with mult's booked slot.
        next(4'b0100, 1'b0, 4'h0);
        check("t2_issue_mult", 64'(issue_a), 64'b0100);
        push_a(cyc + 3, 2);
        idle(1);
        next(4'b1000, 1'b0, 4'h0);
        check("t2_mem_blocked", 64'(issue_a), 64'h0);
        next(4'b1000, 1'b0, 4'h0);
        check("t2_mem_granted", 64'(issue_a), 64'b1000);
        push_a(cyc + 1, 3);
        idle(3);

        // Test 3: divider re-requests while busy.
        next(4'b0010, 1'b0, 4'h0);
        check("t3_issue_div", 64'(issue_a), 64'b0010);
        push_a(cyc + 6, 1);
        for (int k = 1; k <= 6; k++) begin
            next(4'b0010, 1'b0, 4'h0);
            check("t3_div_held", 64'(issue_a), 64'h0);
            check("t3_div_busy", 64'(busy_a), 64'b0010);
        end
        next(4'b0010, 1'b0, 4'h0);
        check("t3_div_regrant", 64'(issue_a), 64'b0010);
        push_a(cyc + 6, 1);
        idle(8);

        // Test 4: equal latencies rotate round-robin on dut_b.
        for (int k = 0; k < 5; k++) begin
            next(4'h0, 1'b0, 4'hF);
            check("t4_rr_issue", 64'(issue_b), 64'(t4_issue[k]));
            push_b(cyc + 2, t4_src[k]);
        end
        idle(4);

        // Test 5: flush drops bookings, busy and a would-be L=0 grant.
        next(4'b0110, 1'b0, 4'h0);
        check("t5_issue", 64'(issue_a), 64'b0110);
        next(4'h0, 1'b0, 4'h0);
        check("t5_busy_pre", 64'(busy_a), 64'b0010);
        next(4'b0001, 1'b1, 4'h0);
        check("t5_flush_issue", 64'(issue_a), 64'h0);
        check("t5_flush_valid", 64'(cdb_valid_a), 64'h0);
        next(4'b0010, 1'b0, 4'h0);
        check("t5_busy_post", 64'(busy_a), 64'h0);
        check("t5_div_regrant", 64'(issue_a), 64'b0010);
        push_a(cyc + 6, 1);
        idle(8);

        // Test 6: reset mid-operation.
        next(4'hF, 1'b0, 4'hF);
        push_a(cyc, 0);
        check("t6_pre_issue_b", 64'(issue_b), 64'b0010);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("t6_rst_issue_a", 64'(issue_a), 64'h0);
        check("t6_rst_busy_a", 64'(busy_a), 64'h0);
        check("t6_rst_valid_a", 64'(cdb_valid_a), 64'h0);
        check("t6_rst_src_a", 64'(src_a), 64'h0);
        check("t6_rst_data_a", 64'(data_a), 64'h0);
        check("t6_rst_issue_b", 64'(issue_b), 64'h0);
        check("t6_rst_busy_b", 64'(busy_b), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; ready_a = '0; ready_b = '0;
        idle(8);
        check("t6_busy_a_after", 64'(busy_a), 64'h0);
        next(4'h0, 1'b0, 4'hF);
        check("t6_rr_reset", 64'(issue_b), 64'b0001);
        push_b(cyc + 2, 0);
        idle(4);

        check("queue_a_drained", 64'(exp_a.size()), 64'h0);
        check("queue_b_drained", 64'(exp_b.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
